// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: signal bundle between the sequencer and its datapath/memory
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [15:0] instruction;
    logic C, L, F, Z, N;
    logic mem_ready, stall;
    logic [3:0] alu_op;
    logic [1:0] pc_sel, wb_sel;
    logic ir_en, reg_we, flag_we, mem_read, mem_write, imm_sel, link, fault;
    logic [2:0] state;
    logic [CNT_W-1:0] retired;

    modport master (
        input instruction, C, L, F, Z, N, mem_ready, stall,
        output alu_op, pc_sel, wb_sel, ir_en, reg_we, flag_we, mem_read, mem_write,
               imm_sel, link, fault, state, retired
    );
    modport slave (
        output instruction, C, L, F, Z, N, mem_ready, stall,
        input alu_op, pc_sel, wb_sel, ir_en, reg_we, flag_we, mem_read, mem_write,
              imm_sel, link, fault, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute sequencer with memory-wait timeout, stall freeze and retired count
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, BRANCH = 3'd4, FAULT = 3'd7
    } state_t;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t st, nxt, cur;
    logic [7:0] wait_q;
    logic [CNT_W-1:0] retired_q;
    logic [3:0] op, ext, fn, alu_code;
    logic [15:0] cond_tab;
    logic is_imm, is_arith, is_shift, is_load, is_stor, is_jal, is_jcond, is_bcond;
    logic is_cmp, is_mov, sets_flags, taken, waiting, timed_out, go, unused;

    assign op = bus.instruction[15:12];
    assign ext = bus.instruction[7:4];
    assign unused = ^bus.instruction[3:0];
    assign is_imm = op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b1111};
    // register and immediate forms share one function-code space
    assign fn = is_imm ? op : ext;
    assign is_arith = is_imm || (op == 4'b0000 &&
                      ext inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101});
    assign is_shift = op == 4'b1000;
    assign is_load = op == 4'b0100 && ext == 4'b0000;
    assign is_stor = op == 4'b0100 && ext == 4'b0100;
    assign is_jal = op == 4'b0100 && ext == 4'b1000;
    assign is_jcond = op == 4'b0100 && ext == 4'b1100;
    assign is_bcond = op == 4'b1100;
    assign is_cmp = is_arith && fn == 4'b1011;
    assign is_mov = is_arith && fn == 4'b1101;
    assign sets_flags = is_arith && fn inside {4'b0101, 4'b1001, 4'b1011};
    assign cond_tab = {1'b0, 1'b1, bus.N | bus.Z, !bus.N & !bus.Z, bus.L | bus.Z, !bus.L & !bus.Z,
                       !bus.F, bus.F, !bus.N, bus.N, !bus.L, bus.L, !bus.C, bus.C, !bus.Z, bus.Z};
    assign taken = is_jal || cond_tab[bus.instruction[11:8]];
    assign waiting = (st == FETCH || st == MEM) && !bus.mem_ready && !bus.stall;
    assign timed_out = waiting && wait_q >= WAIT_LAST;
    assign go = bus.mem_ready && !bus.stall;
    // while reset is held the outputs show the FETCH decode
    assign cur = reset ? FETCH : st;
    assign bus.state = cur;
    assign bus.retired = retired_q;

    always_comb begin
        alu_code = 4'b0000;
        case (fn)
            4'b0101: alu_code = 4'b1000;
            4'b1001: alu_code = 4'b0001;
            4'b1011: alu_code = 4'b0010;
            4'b0001: alu_code = 4'b0011;
            4'b0010: alu_code = 4'b0100;
            4'b0011: alu_code = 4'b0101;
            4'b1111: alu_code = 4'b0110;
            default: alu_code = 4'b0000;
        endcase
    end

    always_comb begin
        nxt = st;
        if (!bus.stall) begin
            case (st)
                FETCH: nxt = bus.mem_ready ? DECODE : timed_out ? FAULT : FETCH;
                MEM: nxt = bus.mem_ready ? FETCH : timed_out ? FAULT : MEM;
                DECODE: nxt = (is_load || is_stor) ? MEM : (is_jal || is_jcond || is_bcond) ? BRANCH : EXEC;
                EXEC, BRANCH: nxt = FETCH;
                default: nxt = FAULT;
            endcase
        end
    end

    always_comb begin
        bus.alu_op = 4'b0000;
        bus.pc_sel = 2'b00;
        bus.wb_sel = 2'b00;
        bus.ir_en = 1'b0;
        bus.reg_we = 1'b0;
        bus.flag_we = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.imm_sel = 1'b0;
        bus.link = 1'b0;
        bus.fault = 1'b0;
        case (cur)
            FETCH: begin
                bus.mem_read = 1'b1;
                bus.ir_en = go && !reset;
            end
            EXEC: begin
                bus.alu_op = is_shift ? 4'b0111 : is_arith ? alu_code : 4'b0000;
                bus.pc_sel = {1'b0, !bus.stall};
                bus.reg_we = (is_shift || (is_arith && !is_cmp)) && !bus.stall;
                bus.flag_we = sets_flags && !bus.stall;
                bus.wb_sel = is_mov ? 2'b11 : 2'b00;
                bus.imm_sel = is_imm;
            end
            MEM: begin
                bus.mem_read = is_load;
                bus.mem_write = is_stor && !bus.stall;
                bus.reg_we = is_load && go;
                bus.wb_sel = {1'b0, is_load && go};
                bus.pc_sel = {1'b0, go};
            end
            BRANCH: begin
                bus.pc_sel = bus.stall ? 2'b00 : !taken ? 2'b01 : is_bcond ? 2'b11 : 2'b10;
                bus.reg_we = is_jal && !bus.stall;
                bus.link = is_jal;
                bus.wb_sel = is_jal ? 2'b10 : 2'b00;
            end
            FAULT: bus.fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
            wait_q <= '0;
            retired_q <= '0;
        end else begin
            st <= nxt;
            wait_q <= (nxt != st) ? 8'd0 : waiting ? wait_q + 8'd1 : wait_q;
            retired_q <= retired_q + CNT_W'(bus.pc_sel != 2'b00);
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against an instruction-level reference model
module tb_multicycle_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [1:0] K_EXEC = 2'd0, K_LOAD = 2'd1, K_STOR = 2'd2, K_BR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] alu;
        logic rwe, fwe, imm, lnk;
        logic [1:0] wb, pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, errors = 0, retired_cnt = 0;
    logic [3:0] alu_ext [7] = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    logic [3:0] imm_op [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
    logic [3:0] mem_ext [4] = '{4'h0, 4'h4, 4'h8, 4'hC};

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CW)) bus ();
    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h instr=%04h t=%0t", tag, got, exp, bus.instruction, $time);
        end
    endtask

    task automatic cyc(input logic rdy, input logic stl);
        bus.mem_ready = rdy;
        bus.stall = stl;
        #2;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] fl);
        logic cf, lf, ff, zf, nf;
        {cf, lf, ff, zf, nf} = fl;
        case (c)
            4'd0: return zf;
            4'd1: return !zf;
            4'd2: return cf;
            4'd3: return !cf;
            4'd4: return lf;
            4'd5: return !lf;
            4'd6: return nf;
            4'd7: return !nf;
            4'd8: return ff;
            4'd9: return !ff;
            4'd10: return !lf && !zf;
            4'd11: return lf || zf;
            4'd12: return !nf && !zf;
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input string b);
        if (b == "ADD") return 4'b1000;
        if (b == "SUB") return 4'b0001;
        if (b == "CMP") return 4'b0010;
        if (b == "AND") return 4'b0011;
        if (b == "OR") return 4'b0100;
        if (b == "XOR") return 4'b0101;
        if (b == "LUI") return 4'b0110;
        if (b == "LSH") return 4'b0111;
        return 4'b0000;
    endfunction

    // name the instruction, then derive its committing-cycle outputs from the mnemonic
    function automatic exp_t expect_of(input logic [15:0] i, input logic [4:0] fl);
        exp_t e;
        string b;
        e = '0;
        e.pc = 2'b01;
        b = "NOP";
        case (i[15:12])
            4'h0: case (i[7:4])
                4'h5: b = "ADD";
                4'h9: b = "SUB";
                4'hB: b = "CMP";
                4'h1: b = "AND";
                4'h2: b = "OR";
                4'h3: b = "XOR";
                4'hD: b = "MOV";
                default: ;
            endcase
            4'h8: b = "LSH";
            4'h4: case (i[7:4])
                4'h0: b = "LOAD";
                4'h4: b = "STOR";
                4'h8: b = "JAL";
                4'hC: b = "JCOND";
                default: ;
            endcase
            4'hC: b = "BCOND";
            4'h1: begin b = "AND"; e.imm = 1'b1; end
            4'h2: begin b = "OR"; e.imm = 1'b1; end
            4'h3: begin b = "XOR"; e.imm = 1'b1; end
            4'h5: begin b = "ADD"; e.imm = 1'b1; end
            4'h9: begin b = "SUB"; e.imm = 1'b1; end
            4'hB: begin b = "CMP"; e.imm = 1'b1; end
            4'hD: begin b = "MOV"; e.imm = 1'b1; end
            4'hF: begin b = "LUI"; e.imm = 1'b1; end
            default: ;
        endcase
        if (b == "LOAD") begin
            e.kind = K_LOAD; e.rwe = 1'b1; e.wb = 2'b01;
        end else if (b == "STOR") begin
            e.kind = K_STOR;
        end else if (b == "JAL") begin
            e.kind = K_BR; e.pc = 2'b10; e.rwe = 1'b1; e.lnk = 1'b1; e.wb = 2'b10;
        end else if (b == "JCOND" || b == "BCOND") begin
            e.kind = K_BR;
            if (cond_true(i[11:8], fl)) e.pc = (b == "JCOND") ? 2'b10 : 2'b11;
        end else begin
            e.alu = alu_of(b);
            e.rwe = !(b == "CMP" || b == "NOP");
            e.fwe = b == "ADD" || b == "SUB" || b == "CMP";
            e.wb = (b == "MOV") ? 2'b11 : 2'b00;
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 5))
            0: begin r[15:12] = 4'h0; r[7:4] = alu_ext[$urandom_range(0, 6)]; end
            1: r[15:12] = imm_op[$urandom_range(0, 7)];
            2: begin r[15:12] = 4'h4; r[7:4] = mem_ext[$urandom_range(0, 3)]; end
            3: r[15:12] = 4'hC;
            4: r[15:12] = 4'h8;
            default: ;
        endcase
        return r;
    endfunction

    // one full instruction: fw fetch waits, mw memory waits, sn stall cycles per phase
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] fl, input int fw, input int mw, input int sn);
        exp_t e;
        logic [2:0] ph;
        e = expect_of(ins, fl);
        ph = (e.kind == K_EXEC) ? 3'd2 : (e.kind == K_BR) ? 3'd4 : 3'd3;
        bus.instruction = ins;
        {bus.C, bus.L, bus.F, bus.Z, bus.N} = fl;
        for (int k = 0; k < sn + fw; k++) begin
            cyc(k < sn ? 1'($urandom) : 1'b0, k < sn);
            chk("fetch_state", bus.state, 0);
            chk("fetch_rd", bus.mem_read, 1);
            chk("fetch_ir", bus.ir_en, 0);
            adv();
        end
        cyc(1'b1, 1'b0);
        chk("fetch_ir_en", bus.ir_en, 1);
        chk("fetch_pc", bus.pc_sel, 0);
        adv();
        for (int k = 0; k <= sn; k++) begin
            cyc(1'($urandom), k < sn);
            chk("decode_state", bus.state, 1);
            chk("decode_pc", bus.pc_sel, 0);
            adv();
        end
        for (int k = 0; k < sn; k++) begin
            cyc(1'($urandom), 1'b1);
            chk("stall_state", bus.state, ph);
            chk("stall_pc", bus.pc_sel, 0);
            chk("stall_rwe", bus.reg_we, 0);
            chk("stall_fwe", bus.flag_we, 0);
            chk("stall_wr", bus.mem_write, 0);
            adv();
        end
        if (e.kind == K_LOAD || e.kind == K_STOR) begin
            for (int k = 0; k < mw; k++) begin
                cyc(1'b0, 1'b0);
                chk("memwait_state", bus.state, 3);
                chk("memwait_rd", bus.mem_read, e.kind == K_LOAD);
                chk("memwait_wr", bus.mem_write, e.kind == K_STOR);
                chk("memwait_rwe", bus.reg_we, 0);
                chk("memwait_wb", bus.wb_sel, 0);
                chk("memwait_pc", bus.pc_sel, 0);
                adv();
            end
        end
        cyc(1'b1, 1'b0);
        chk("commit_state", bus.state, ph);
        chk("commit_pc", bus.pc_sel, e.pc);
        chk("commit_rwe", bus.reg_we, e.rwe);
        chk("commit_fwe", bus.flag_we, e.fwe);
        chk("commit_wb", bus.wb_sel, e.wb);
        chk("commit_link", bus.link, e.lnk);
        chk("commit_fault", bus.fault, 0);
        if (e.kind == K_EXEC) begin
            chk("commit_alu", bus.alu_op, e.alu);
            chk("commit_imm", bus.imm_sel, e.imm);
        end else if (e.kind != K_BR) begin
            chk("commit_rd", bus.mem_read, e.kind == K_LOAD);
            chk("commit_wr", bus.mem_write, e.kind == K_STOR);
        end
        adv();
        retired_cnt++;
        chk("retired", bus.retired, retired_cnt % (1 << CW));
        chk("back_to_fetch", bus.state, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b1, 1'b0);
        adv();
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk("post_rst_state", bus.state, 0);
        chk("post_rst_retired", bus.retired, 0);
        chk("post_rst_fault", bus.fault, 0);
        retired_cnt = 0;
    endtask

    initial begin
        bus.instruction = '0;
        {bus.C, bus.L, bus.F, bus.Z, bus.N} = '0;
        cyc(1'b1, 1'b1);
        adv();
        cyc(1'b1, 1'b0);
        chk("rst_state", bus.state, 0);
        chk("rst_rd", bus.mem_read, 1);
        chk("rst_ir", bus.ir_en, 0);
        chk("rst_pc", bus.pc_sel, 0);
        chk("rst_fault", bus.fault, 0);
        adv();
        do_reset();
        run_instr(16'h0152, 5'b0, 0, 0, 0);
        run_instr(16'h4103, 5'b0, 0, 3, 0);
        run_instr(16'h9105, 5'b0, 0, 0, 2);
        run_instr(16'hC005, 5'b00000, 0, 0, 0);
        run_instr(16'hC005, 5'b00010, 0, 0, 0);
        run_instr(16'h4EC0, 5'b0, 0, 0, 0);
        run_instr(16'h4080, 5'b0, 1, 0, 1);
        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), 5'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
        // fetch never completes: fault after TO waiting cycles, sticky until reset
        bus.instruction = 16'h0000;
        for (int k = 0; k < TO; k++) begin
            cyc(1'b0, 1'b0);
            chk("to_fetch_state", bus.state, 0);
            adv();
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'($urandom), k > 0 ? 1'($urandom) : 1'b0);
            chk("fault_state", bus.state, 7);
            chk("fault_flag", bus.fault, 1);
            chk("fault_pc", bus.pc_sel, 0);
            chk("fault_rd", bus.mem_read, 0);
            chk("fault_ir", bus.ir_en, 0);
            chk("fault_rwe", bus.reg_we, 0);
            adv();
        end
        do_reset();
        // memory stage never completes
        bus.instruction = 16'h4203;
        cyc(1'b1, 1'b0);
        adv();
        cyc(1'b0, 1'b0);
        adv();
        for (int k = 0; k < TO; k++) begin
            cyc(1'b0, 1'b0);
            chk("to_mem_state", bus.state, 3);
            adv();
        end
        cyc(1'b1, 1'b0);
        chk("mem_fault_state", bus.state, 7);
        chk("mem_fault_flag", bus.fault, 1);
        adv();
        do_reset();
        run_instr(16'h0152, 5'b0, 0, 0, 0);
        // reset lands in the middle of a store
        bus.instruction = 16'h4040;
        cyc(1'b1, 1'b0);
        adv();
        cyc(1'b0, 1'b0);
        adv();
        cyc(1'b0, 1'b0);
        chk("mid_mem_state", bus.state, 3);
        chk("mid_mem_wr", bus.mem_write, 1);
        adv();
        reset = 1'b1;
        cyc(1'b1, 1'b0);
        chk("rst_mem_state", bus.state, 0);
        chk("rst_mem_rd", bus.mem_read, 1);
        chk("rst_mem_wr", bus.mem_write, 0);
        chk("rst_mem_pc", bus.pc_sel, 0);
        adv();
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk("after_mem_rst_state", bus.state, 0);
        chk("after_mem_rst_retired", bus.retired, 0);
        retired_cnt = 0;
        for (int n = 0; n < 17; n++) run_instr(16'h0000, 5'($urandom), 0, 0, 0);
        chk("wrap", bus.retired, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
